// File: rtl/button_pkg.sv
// button_pkg: shared arbiter state type and debounce default for the button front end.
package button_pkg;
  typedef enum logic {IDLE, OFFER} arb_state_e;
  localparam int DEBOUNCE_DEFAULT = 50000;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser, counting debouncer and rising-edge press pulse.
module input_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic stable,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] count;
  logic differ, done;
  assign differ = sync[1] ^ stable;
  assign done = differ && count == CW'(DEBOUNCE_CYCLES - 1);
  // press is registered alongside stable so it pulses in the cycle stable first reads 1
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      stable <= 1'b0;
      press <= 1'b0;
      count <= '0;
    end else begin
      sync <= {sync[0], async_in};
      stable <= done ? sync[1] : stable;
      press <= done && sync[1];
      count <= (!differ || done) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounced push-buttons turned into press events shared round-robin
// over a single valid/ready port, with sticky per-channel overflow on lost presses.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int N = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int IDW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   buttons_async,
  output logic [N-1:0]   buttons_stable,
  output logic           event_valid,
  output logic [IDW-1:0] event_id,
  input  logic           event_ready,
  output logic [N-1:0]   overflow,
  input  logic           overflow_clear
);
  arb_state_e state, state_n;
  logic [N-1:0] press, pending, clr;
  logic [IDW-1:0] last_grant, pick, id_n, lg_n;
  logic any, accept;

  for (genvar i = 0; i < N; i++) begin : g_ch
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock(clock),
      .reset(reset),
      .async_in(buttons_async[i]),
      .stable(buttons_stable[i]),
      .press(press[i])
    );
  end

  function automatic logic [IDW-1:0] rr(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N);
  endfunction

  assign event_valid = state == OFFER;
  assign accept = event_valid && event_ready;
  assign clr = accept ? N'(1) << event_id : '0;

  // scanning from farthest to nearest leaves the first pending channel after last_grant in pick
  always_comb begin
    pick = '0;
    any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      pick = pending[rr(last_grant, k)] ? rr(last_grant, k) : pick;
      any = any | pending[rr(last_grant, k)];
    end
    state_n = state;
    id_n = event_id;
    lg_n = last_grant;
    if (state == IDLE && any) begin
      state_n = OFFER;
      id_n = pick;
    end else if (accept) begin
      state_n = IDLE;
      lg_n = event_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      event_id <= '0;
      last_grant <= IDW'(N - 1);
      pending <= '0;
      overflow <= '0;
    end else begin
      state <= state_n;
      event_id <= id_n;
      last_grant <= lg_n;
      pending <= (pending & ~clr) | press;
      overflow <= (overflow_clear ? '0 : overflow) | (press & pending & ~clr);
    end
  end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Front-end controller for the board push-buttons. It passes N asynchronous button inputs through per-channel synchronisers and debouncers, and turns each debounced press into a pending event. A round-robin arbiter shares a single valid/ready event port between the channels. Sits between the raw board pins and the processor's memory-mapped input peripheral.

Parameters:
N, 4, number of button channels (2..16)
DEBOUNCE_CYCLES, 50000, consecutive differing samples required to accept a level change (1 ms at 50 MHz; >=2)
IDW, $clog2(N), width of event_id (derived; not overridden)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
buttons_async  input  N  raw asynchronous button levels, 1 = pressed
buttons_stable  output  N  debounced button levels
event_valid  output  1  an event is offered on event_id
event_id  output  IDW  channel index of the offered press event
event_ready  input  1  consumer accepts the event when high with event_valid
overflow  output  N  sticky per channel: a press was lost
overflow_clear  input  1  clears all overflow bits

Behaviour:
- Reset (clock edge with reset=1): sync flops, buttons_stable, debounce counters, pending, overflow, event_valid, event_id all 0; last_grant = N-1, so channel 0 has first priority; FSM to IDLE. Reset overrides every other input.
- Synchronise: two flops per channel, sync = buttons_async delayed 2 cycles.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES):
  - if sync == stable: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - else counter++.
  - So buttons_stable changes exactly DEBOUNCE_CYCLES cycles after sync first differs, provided sync holds. Any glitch back resets the count.
- Press detection: press[i] = one-cycle pulse on stable[i] 0->1. Releases generate no event.
- pending[i]:
  - set on press[i];
  - cleared on an accepted handshake for channel i;
  - if press[i] and clear coincide, pending stays 1 (new event retained).
- overflow[i]:
  - set when press[i] occurs while pending[i]=1 and it is not cleared that cycle;
  - cleared when overflow_clear=1;
  - set wins over overflow_clear in the same cycle.
- FSM, states IDLE and OFFER:
  - IDLE: if any pending, select the first pending channel searching from last_grant+1 upward, modulo N. Register event_id and set event_valid=1, then go to OFFER. If none pending, stay with event_valid=0.
  - OFFER: event_valid=1; event_id held stable until accepted.
    - On event_ready=1: clear pending[event_id], last_grant <= event_id, event_valid <= 0, go to IDLE.
    - event_ready=0: remain in OFFER.
  - Throughput: at most one event per 2 cycles.
  - Latency: press pulse to event_valid = 2 cycles, when idle and uncontested.
- Fairness: a pending channel is granted within N handshakes.
- event_valid never deasserts without a handshake, except on reset.
- event_ready while event_valid=0 is ignored.

Decomposition:
- Package button_pkg: the arbiter state enum (IDLE, OFFER) and DEBOUNCE_DEFAULT = 50000.
- Sub-module input_debouncer, instantiated N times. It contains the 2-flop synchroniser, debounce counter, stable register and press pulse. Parameter DEBOUNCE_CYCLES; ports clock, reset, async_in, stable, press.
- Arbiter and FSM stay in the top module.

Test Plan:
(Use DEBOUNCE_CYCLES=4, N=4.)
1. Single press: raise buttons_async[2] and hold. buttons_stable[2]=1 six cycles after the first sampling edge (2 sync + 4). event_valid=1, event_id=2 two cycles later. With event_ready=1 for one cycle, event_valid=0 next cycle and pending[2] clears.
2. Bounce: toggle buttons_async[1] with 3-cycle pulses 0/1/0/1, then hold 1. buttons_stable[1] rises exactly once, 4 cycles after the final rise reaches sync. Exactly one event_id=1 is produced.
3. Round-robin: presses on channels 0, 1 and 3 land in the same cycle, with event_ready tied 1. Events appear in order 0, 1, 3. A later simultaneous 0 and 3 yields 0 first (last_grant=3 wraps to 0).
4. Backpressure and overflow: channel 2 pending, event_ready=0. Release and re-press channel 2. overflow[2]=1 and event_id stays 2. Assert event_ready: one event only. Pulse overflow_clear: overflow[2]=0.
5. Coincident press and accept: a new press[0] pulse in the same cycle as the channel-0 handshake. pending[0] stays 1 and a second event_id=0 is offered 2 cycles later.
6. Reset mid-offer: assert reset while event_valid=1. At the next edge event_valid=0, pending=0, buttons_stable=0. After release, channel 0 wins the first contest against channel 3.
